// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// the round-robin history encoding and the conflict counter width.
package reg_wb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 8;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_grant_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: grants the sole valid requester, or on a tie
// the one that did not win most recently. Grants are one-hot or all-zero.
module rr_pick2
    import reg_wb_pkg::*;
(
    input  logic        a_valid,
    input  logic        b_valid,
    input  last_grant_e last_grant,
    output logic        a_grant,
    output logic        b_grant
);

    assign a_grant = a_valid && (!b_valid || (last_grant == LAST_B));
    assign b_grant = b_valid && (!a_valid || (last_grant == LAST_A));

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto a single register-file
// write port with one cycle of registered latency and a tie counter.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              sel,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              req_ok;
    logic              a_grant;
    logic              b_grant;
    last_grant_e       last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Readies are forced low during stall and while reset is held.
    assign req_ok = rst_n && !stall;

    rr_pick2 u_pick (
        .a_valid    (a_valid && req_ok),
        .b_valid    (b_valid && req_ok),
        .last_grant (last_grant_q),
        .a_grant    (a_grant),
        .b_grant    (b_grant)
    );

    assign a_ready = a_grant;
    assign b_ready = b_grant;

    always_comb begin
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        // Register 0 is hardwired, so its writes complete without a strobe.
        if (a_grant) begin
            wr_en_d      = |a_addr;
            wr_addr_d    = a_addr;
            wr_data_d    = a_data;
            sel_d        = 1'b0;
            last_grant_d = LAST_A;
        end else if (b_grant) begin
            wr_en_d      = |b_addr;
            wr_addr_d    = b_addr;
            wr_data_d    = b_data;
            sel_d        = 1'b1;
            last_grant_d = LAST_B;
        end
        if (a_valid && b_valid && !stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= LAST_B;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            sel_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign sel          = sel_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed vector table, hand-written
// reset/stall/saturation sequences, and randomized traffic against a model.
module tb_reg_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          a_valid = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          sel;
    logic [7:0]    conflict_cnt;

    int errors = 0;
    int checks = 0;

    reg_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .sel          (sel),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st;
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          bv;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic          x_ar;
        logic          x_br;
        logic          x_en;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_data;
        logic          x_sel;
        logic [7:0]    x_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives inputs at a point well away from the rising edge.
    task automatic applyStimulus(input logic st, input logic av, input logic [AW-1:0] aa,
                                 input logic [DW-1:0] ad, input logic bv,
                                 input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        stall   = st;
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model state
    bit            m_b_won_last;
    bit            m_en;
    bit [AW-1:0]   m_addr;
    bit [DW-1:0]   m_data;
    bit            m_sel;
    int            m_cnt;
    bit            pa_v, pb_v;
    bit [AW-1:0]   pa_a, pb_a;
    bit [DW-1:0]   pa_d, pb_d;
    int            a_sent, b_sent, a_made, b_made;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 1'b0, 1'b1, 5'd1, 32'hA1, 1'b0, 8'd1};
        vecs[1] = '{1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b1, 1'b1, 5'd2, 32'hB2, 1'b1, 8'd2};
        vecs[2] = '{1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 1'b0, 1'b1, 5'd1, 32'hA1, 1'b0, 8'd3};
        vecs[3] = '{1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b1, 1'b1, 5'd2, 32'hB2, 1'b1, 8'd4};
        vecs[4] = '{1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 8'd4};
        vecs[5] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'hFF, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFF, 1'b1, 8'd4};
        vecs[6] = '{1'b0, 1'b0, 5'd7, 32'h77, 1'b0, 5'd9, 32'h99, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFF, 1'b1, 8'd4};
        vecs[7] = '{1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFF, 1'b1, 8'd4};

        // Reset values and readies held low during reset
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        checkOutput("ready_a_in_reset", a_ready, 0);
        checkOutput("ready_b_in_reset", b_ready, 0);
        checkOutput("wr_en_reset", wr_en, 0);
        checkOutput("wr_addr_reset", wr_addr, 0);
        checkOutput("wr_data_reset", wr_data, 0);
        checkOutput("sel_reset", sel, 0);
        checkOutput("cnt_reset", conflict_cnt, 0);
        doReset();

        // Directed vector table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].av, vecs[i].aa, vecs[i].ad,
                          vecs[i].bv, vecs[i].ba, vecs[i].bd);
            checkOutput($sformatf("v%0d_a_ready", i), a_ready, vecs[i].x_ar);
            checkOutput($sformatf("v%0d_b_ready", i), b_ready, vecs[i].x_br);
            tick();
            checkOutput($sformatf("v%0d_wr_en", i), wr_en, vecs[i].x_en);
            checkOutput($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].x_addr);
            checkOutput($sformatf("v%0d_wr_data", i), wr_data, vecs[i].x_data);
            checkOutput($sformatf("v%0d_sel", i), sel, vecs[i].x_sel);
            checkOutput($sformatf("v%0d_cnt", i), conflict_cnt, vecs[i].x_cnt);
        end

        // Stall right after reset: no grants, then A wins the first tie
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88);
            checkOutput("stall_a_ready", a_ready, 0);
            checkOutput("stall_b_ready", b_ready, 0);
            tick();
            checkOutput("stall_wr_en", wr_en, 0);
            checkOutput("stall_cnt", conflict_cnt, 0);
        end
        applyStimulus(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88);
        checkOutput("unstall_a_first", a_ready, 1);
        checkOutput("unstall_b_wait", b_ready, 0);
        tick();
        checkOutput("unstall_wr_addr", wr_addr, 6);

        // Reset the cycle after an A transfer
        doReset();
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
        tick();
        checkOutput("pre_rst_wr_en", wr_en, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_wr_en", wr_en, 0);
        checkOutput("mid_rst_a_ready", a_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        checkOutput("post_rst_a_wins", a_ready, 1);
        tick();

        // Saturation of the conflict counter
        doReset();
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        repeat (300) tick();
        checkOutput("cnt_saturate", conflict_cnt, 255);

        // Randomized traffic against the reference model
        doReset();
        m_b_won_last = 1'b1;
        m_en = 0; m_addr = '0; m_data = '0; m_sel = 0; m_cnt = 0;
        pa_v = 0; pb_v = 0; pa_a = '0; pb_a = '0; pa_d = '0; pb_d = '0;
        a_sent = 0; b_sent = 0; a_made = 0; b_made = 0;
        for (int c = 0; c < 500; c++) begin
            bit st, ga, gb;
            if (!pa_v && ($urandom_range(0, 2) != 0)) begin
                pa_v = 1; pa_a = AW'($urandom); pa_d = $urandom; a_made++;
            end
            if (!pb_v && ($urandom_range(0, 2) != 0)) begin
                pb_v = 1; pb_a = AW'($urandom); pb_d = $urandom; b_made++;
            end
            st = ($urandom_range(0, 4) == 0);
            applyStimulus(st, pa_v, pa_a, pa_d, pb_v, pb_a, pb_d);
            ga = 0; gb = 0;
            if (!st) begin
                if (pa_v && pb_v) begin
                    ga = m_b_won_last;
                    gb = !m_b_won_last;
                end else begin
                    ga = pa_v;
                    gb = pb_v;
                end
            end
            checkOutput("rnd_a_ready", a_ready, ga);
            checkOutput("rnd_b_ready", b_ready, gb);
            if (pa_v && pb_v && !st && m_cnt < 255) m_cnt++;
            m_en = 0;
            if (ga) begin
                m_en = (pa_a != 0); m_addr = pa_a; m_data = pa_d; m_sel = 0;
                m_b_won_last = 0; pa_v = 0; a_sent++;
            end else if (gb) begin
                m_en = (pb_a != 0); m_addr = pb_a; m_data = pb_d; m_sel = 1;
                m_b_won_last = 1; pb_v = 0; b_sent++;
            end
            tick();
            checkOutput("rnd_wr_en", wr_en, m_en);
            checkOutput("rnd_wr_addr", wr_addr, m_addr);
            checkOutput("rnd_wr_data", wr_data, m_data);
            checkOutput("rnd_sel", sel, m_sel);
            checkOutput("rnd_cnt", conflict_cnt, m_cnt);
        end
        checkOutput("rnd_a_no_drop", a_sent + int'(pa_v), a_made);
        checkOutput("rnd_b_no_drop", b_sent + int'(pb_v), b_made);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
